// File: rtl/program_loader.sv
// program_loader: buffers host program bytes and feeds them to the control block during its RAM-programming instruction cycles
module program_loader #(
  parameter int PROG_WORDS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       cpu_ready,
  input  logic       cpu_read_ui_in,
  input  logic       cpu_done_load,
  output logic       programming,
  output logic [7:0] load_data,
  output logic [3:0] load_addr,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [2:0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PROG_WORDS + 1);
  typedef enum logic [1:0] {IDLE, ARM, LOAD, FINISH} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] accepted;
  logic          push, pop, last;
  assign host_ready = (state == ARM || state == LOAD) && level != LW'(FIFO_DEPTH) && accepted < CW'(PROG_WORDS);
  assign push       = host_valid && host_ready;
  assign pop        = state == LOAD && cpu_done_load && level != '0;
  assign last       = load_addr == 4'(PROG_WORDS - 1);
  assign load_data  = level != '0 ? mem[rd_ptr] : 8'h00;
  assign busy       = state != IDLE;
  assign fifo_level = 3'(level);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= host_data;
  // programming only moves on cpu_ready edges so it never changes inside an instruction cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      programming <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      load_addr   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      accepted    <= '0;
    end else begin
      done <= 1'b0;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        accepted <= accepted + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      case (state)
        IDLE: if (start) begin
          state     <= ARM;
          load_addr <= '0;
          accepted  <= '0;
          underrun  <= 1'b0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          level     <= '0;
        end
        ARM: if (cpu_ready && level != '0) begin
          state       <= LOAD;
          programming <= 1'b1;
        end
        LOAD: begin
          if (cpu_read_ui_in && level == '0) underrun <= 1'b1;
          if (cpu_done_load) begin
            load_addr <= last ? 4'd0 : load_addr + 4'd1;
            if (last) state <= FINISH;
          end
        end
        FINISH: if (cpu_ready) begin
          state       <= IDLE;
          programming <= 1'b0;
          done        <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized bench with a queue-level loader model and a T0..T6 control-block model
module tb_program_loader;
  localparam int PW = 16, FD = 4;
  logic clk = 0, reset = 1, start = 0, host_valid = 0;
  logic cpu_ready = 0, cpu_read_ui_in = 0, cpu_done_load = 0;
  logic [7:0] host_data = 0;
  logic host_ready, programming, busy, done, underrun;
  logic [7:0] load_data;
  logic [3:0] load_addr;
  logic [2:0] fifo_level;
  int checks = 0, fails = 0;
  program_loader #(.PROG_WORDS(PW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .cpu_ready(cpu_ready), .cpu_read_ui_in(cpu_read_ui_in),
    .cpu_done_load(cpu_done_load), .programming(programming), .load_data(load_data),
    .load_addr(load_addr), .busy(busy), .done(done), .underrun(underrun), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  bit cb_en, host_gap, noise;
  int phase, n_acc, n_done;
  logic [7:0] cb_latch, cb_ram [16];
  logic [7:0] src [$];
  bit m_active, m_prog, m_done, m_under;
  int m_slot, m_acc;
  logic [7:0] m_latch, exp_ram [16];
  logic [7:0] m_q [$];
  wire [19:0] dut_vec = {busy, programming, done, underrun, host_ready, fifo_level, load_addr, load_data};

  function automatic logic [19:0] exp_vec();
    logic rdy;
    rdy = m_active && m_slot < PW && m_q.size() < FD && m_acc < PW;
    return {m_active, m_prog, m_done, m_under, rdy, 3'(m_q.size()), 4'(m_slot % 16),
            m_q.size() > 0 ? m_q[0] : 8'h00};
  endfunction

  // session-level reference: a byte queue, a slot count and the idle/arming/loading/finishing phases
  task automatic model_edge();
    bit push;
    push = host_valid && m_active && m_slot < PW && m_q.size() < FD && m_acc < PW;
    m_done = 0;
    if (reset) begin
      m_active = 0; m_prog = 0; m_under = 0; m_slot = 0; m_acc = 0; m_q.delete();
      return;
    end
    if (!m_active) begin
      if (start) begin m_active = 1; m_slot = 0; m_acc = 0; m_under = 0; m_q.delete(); end
    end else if (!m_prog) begin
      if (cpu_ready && m_q.size() > 0) m_prog = 1;
    end else if (m_slot < PW) begin
      if (cpu_read_ui_in) begin
        m_latch = m_q.size() > 0 ? m_q[0] : 8'h00;
        if (m_q.size() == 0) m_under = 1;
      end
      if (cpu_done_load) begin
        exp_ram[m_slot] = m_latch;
        m_slot++;
        if (m_q.size() > 0) void'(m_q.pop_front());
      end
    end else if (cpu_ready) begin
      m_active = 0; m_prog = 0; m_done = 1;
    end
    if (push) begin m_q.push_back(host_data); m_acc++; end
  endtask

  // called at a negedge with inputs set; advances one clock and drives the next cycle's inputs
  task automatic step();
    bit acc;
    acc = host_valid && host_ready;
    if (cpu_read_ui_in) cb_latch = load_data;
    if (cpu_done_load) cb_ram[load_addr] = cb_latch;
    if (acc) begin void'(src.pop_front()); n_acc++; end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (done) n_done++;
    phase = (phase + 1) % 7;
    start = noise && m_active && $urandom_range(7) == 0;
    cpu_ready = cb_en && phase == 0;
    cpu_read_ui_in = cb_en && phase == 3 && programming;
    cpu_done_load = cb_en && phase == 4 && programming;
    host_valid = src.size() > 0 && (!host_gap || $urandom_range(2) != 0);
    host_data = src.size() > 0 ? src[0] : 8'($urandom);
  endtask

  task automatic reset_dut();
    cb_en = 0; host_gap = 0; noise = 0; src.delete();
    reset = 1; step(); reset = 0;
    n_acc = 0; n_done = 0;
    for (int i = 0; i < 16; i++) cb_ram[i] = 8'hAA;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (dut_vec !== 20'h0) begin fails++; $display("FAIL reset_idle got=%h exp=0", dut_vec); end
    src = '{8'h5A, 8'hA5, 8'h33};
    start = 1; step(); step(); step();
    checks++; if ({busy, fifo_level} !== 4'b1010 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_prearm got=%h exp=%h", dut_vec, exp_vec()); end
    reset = 1; start = 1; cpu_ready = 1; cpu_read_ui_in = 1; cpu_done_load = 1;
    step(); reset = 0;
    checks++; if (dut_vec !== 20'h0 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_dominates got=%h exp=0", dut_vec); end
    step();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_nominal();
    bit prog_prev;
    reset_dut();
    for (int i = 0; i < PW; i++) src.push_back(8'(8'h10 + i));
    cb_en = 1; phase = $urandom_range(6, 1); prog_prev = 0;
    start = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL nominal c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (programming !== prog_prev) begin
        checks++; if (phase != 1) begin fails++; $display("FAIL align_prog phase=%0d exp=1", phase); end
      end
      prog_prev = programming;
      if (!m_active) break;
    end
    checks++; if (n_done != 1 || underrun !== 1'b0) begin fails++; $display("FAIL nominal_end done_cnt=%0d underrun=%b exp=1/0", n_done, underrun); end
    for (int i = 0; i < PW; i++) begin
      checks++; if (cb_ram[i] !== 8'(8'h10 + i)) begin fails++; $display("FAIL nominal_ram[%0d] got=%h exp=%h", i, cb_ram[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] saved [$];
    reset_dut();
    repeat (8) src.push_back(8'($urandom));
    saved = src;
    start = 1;
    for (int c = 0; c < 7; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL bp_fill c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    checks++; if (host_ready !== 1'b0 || fifo_level !== 3'd4 || n_acc != 4) begin
      fails++; $display("FAIL bp_full ready=%b level=%0d acc=%0d exp=0/4/4", host_ready, fifo_level, n_acc); end
    cpu_ready = 1; step();
    checks++; if (programming !== 1'b1 || host_ready !== 1'b0) begin
      fails++; $display("FAIL bp_load prog=%b ready=%b exp=1/0", programming, host_ready); end
    cpu_done_load = 1; step();
    checks++; if (host_ready !== 1'b1 || fifo_level !== 3'd3 || load_data !== saved[1]) begin
      fails++; $display("FAIL bp_pop ready=%b level=%0d data=%h exp=1/3/%h", host_ready, fifo_level, load_data, saved[1]); end
    step();
    checks++; if (host_ready !== 1'b0 || fifo_level !== 3'd4 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL bp_refill got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_underrun();
    logic [7:0] saved [$];
    reset_dut();
    repeat (3) src.push_back(8'($urandom_range(255, 1)));
    saved = src;
    cb_en = 1; phase = $urandom_range(6, 1);
    start = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL underrun c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (!m_active) break;
    end
    checks++; if (n_done != 1 || underrun !== 1'b1) begin fails++; $display("FAIL underrun_end done_cnt=%0d underrun=%b exp=1/1", n_done, underrun); end
    for (int i = 0; i < PW; i++) begin
      checks++; if (cb_ram[i] !== (i < 3 ? saved[i] : 8'h00)) begin
        fails++; $display("FAIL underrun_ram[%0d] got=%h exp=%h", i, cb_ram[i], i < 3 ? saved[i] : 8'h00); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] saved [$];
    reset_dut();
    repeat (PW) src.push_back(8'($urandom));
    cb_en = 1; phase = $urandom_range(6, 1);
    start = 1;
    for (int c = 0; c < 300; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL rmid c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (m_slot == 7) break;
    end
    checks++; if (load_addr !== 4'd7) begin fails++; $display("FAIL rmid_slot got=%0d exp=7", load_addr); end
    reset = 1; step(); reset = 0;
    checks++; if ({programming, busy, fifo_level, done} !== 6'b0) begin
      fails++; $display("FAIL rmid_abort prog=%b busy=%b level=%0d done=%b exp=0", programming, busy, fifo_level, done); end
    repeat (14) step();
    checks++; if (n_done != 0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_nodone done_cnt=%0d busy=%b exp=0/0", n_done, busy); end
    src.delete();
    repeat (PW) src.push_back(8'($urandom));
    saved = src;
    for (int i = 0; i < 16; i++) cb_ram[i] = 8'hAA;
    start = 1; step();
    checks++; if (load_addr !== 4'd0 || busy !== 1'b1) begin fails++; $display("FAIL rmid_restart addr=%0d busy=%b exp=0/1", load_addr, busy); end
    for (int c = 0; c < 400; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL rmid2 c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (!m_active) break;
    end
    for (int i = 0; i < PW; i++) begin
      checks++; if (cb_ram[i] !== saved[i]) begin fails++; $display("FAIL rmid_ram[%0d] got=%h exp=%h", i, cb_ram[i], saved[i]); end
    end
  endtask

  task automatic test_overrun();
    reset_dut();
    repeat (20) src.push_back(8'($urandom));
    cb_en = 1; phase = $urandom_range(6, 1);
    start = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL overrun c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
      if (n_acc >= PW) begin
        checks++; if (host_ready !== 1'b0) begin fails++; $display("FAIL overrun_ready c=%0d got=1 exp=0", c); end
      end
      if (!m_active) break;
    end
    checks++; if (n_acc != PW || src.size() != 4 || n_done != 1) begin
      fails++; $display("FAIL overrun_count acc=%0d left=%0d done_cnt=%0d exp=16/4/1", n_acc, src.size(), n_done); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int s = 0; s < 6; s++) begin
      src.delete();
      repeat ($urandom_range(20, 1)) src.push_back(8'($urandom));
      for (int i = 0; i < 16; i++) cb_ram[i] = 8'hAA;
      cb_en = 1; host_gap = 1; noise = 1; n_done = 0;
      start = 1;
      for (int c = 0; c < 600; c++) begin
        step();
        checks++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random s=%0d c=%0d got=%h exp=%h", s, c, dut_vec, exp_vec()); end
        if (!m_active) break;
      end
      checks++; if (n_done != 1) begin fails++; $display("FAIL random_done s=%0d got=%0d exp=1", s, n_done); end
      for (int i = 0; i < PW; i++) begin
        checks++; if (cb_ram[i] !== exp_ram[i]) begin fails++; $display("FAIL random_ram s=%0d [%0d] got=%h exp=%h", s, i, cb_ram[i], exp_ram[i]); end
      end
      noise = 0;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_backpressure();
    test_underrun();
    test_reset_mid();
    test_overrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
